// File: rtl/rv151_pkg.sv
// Shared definitions for the rv151 core: writeback source select,
// load funct3 codes and the writeback state machine encoding.
package rv151_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rv151_ld_ext.sv
// Load data extraction: picks the byte/half/word addressed by the low
// address bits and sign- or zero-extends it to 32 bits.
module rv151_ld_ext
  import rv151_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Halfword loads only look at off[1]; a misaligned off[0] is ignored.
  always_comb begin
    ld_byte = raw[{off, 3'b000} +: 8];
    ld_half = off[1] ? raw[31:16] : raw[15:0];
    case (funct3)
      F3_LB:   data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  data = {24'd0, ld_byte};
      F3_LH:   data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  data = {16'd0, ld_half};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/rv151_wbu.sv
// Writeback unit: retires one instruction per handshake into the register
// file write port, waits for load data, and bypasses same-cycle writes.
module rv151_wbu
  import rv151_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_we,
  input  logic [1:0]       in_wbsel,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [2:0]       in_funct3,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  input  logic [XLEN-1:0]  rgf_rd1,
  input  logic [XLEN-1:0]  rgf_rd2,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2,
  output logic             ld_busy,
  output logic [CNT_W-1:0] instret
);

  wb_state_t       state, next_state;
  logic            accept_alu, accept_mem, ld_done;
  logic [4:0]      ld_rd;
  logic            ld_we;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;
  logic [XLEN-1:0] ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && in_wbsel == WB_MEM) next_state = WAIT_LD;
      WAIT_LD: if (dmem_rvalid)                    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    ld_busy    = (state == WAIT_LD);
    accept_alu = in_ready && in_valid && (in_wbsel != WB_MEM);
    accept_mem = in_ready && in_valid && (in_wbsel == WB_MEM);
    ld_done    = ld_busy && dmem_rvalid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rd  <= '0;
      ld_we  <= 1'b0;
      ld_f3  <= '0;
      ld_off <= '0;
    end else if (accept_mem) begin
      ld_rd  <= in_rd;
      ld_we  <= in_we;
      ld_f3  <= in_funct3;
      ld_off <= in_alu[1:0];
    end
  end

  rv151_ld_ext u_ld_ext (
    .funct3 (ld_f3),
    .off    (ld_off),
    .raw    (dmem_rdata),
    .data   (ld_data)
  );

  // rf_we defaults low every cycle so each retirement is a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_wa   <= '0;
      rf_wd   <= '0;
      instret <= '0;
    end else begin
      rf_we <= 1'b0;
      if (accept_alu) begin
        rf_we   <= in_we && (in_rd != 5'd0);
        rf_wa   <= in_rd;
        rf_wd   <= (in_wbsel == WB_PC4) ? in_pc4 : in_alu;
        instret <= instret + CNT_W'(1);
      end else if (ld_done) begin
        rf_we   <= ld_we && (ld_rd != 5'd0);
        rf_wa   <= ld_rd;
        rf_wd   <= ld_data;
        instret <= instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd1 = (rf_we && rf_wa == ra1 && ra1 != 5'd0) ? rf_wd : rgf_rd1;
    rd2 = (rf_we && rf_wa == ra2 && ra2 != 5'd0) ? rf_wd : rgf_rd2;
  end

endmodule

// File: tb/tb_rv151_wbu.sv
// Self-checking bench for rv151_wbu: directed cases followed by random
// retirements checked against a behavioural writeback model.
module tb_rv151_wbu;
  import rv151_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic [1:0]  in_wbsel = '0;
  logic [31:0] in_alu = '0;
  logic [31:0] in_pc4 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rgf_rd1 = '0;
  logic [31:0] rgf_rd2 = '0;
  logic [31:0] rd1, rd2;
  logic        ld_busy;
  logic [63:0] instret;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_instret = '0;
  logic        last_we = 1'b0;
  logic [4:0]  last_wa = '0;
  logic [31:0] last_wd = '0;

  rv151_wbu #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_we(in_we),
    .in_wbsel(in_wbsel), .in_alu(in_alu), .in_pc4(in_pc4), .in_funct3(in_funct3),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .ra1(ra1), .ra2(ra2), .rgf_rd1(rgf_rd1), .rgf_rd2(rgf_rd2),
    .rd1(rd1), .rd2(rd2), .ld_busy(ld_busy), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rd, input logic we, input logic [1:0] wbsel,
                               input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    in_valid  = 1'b1;
    in_rd     = rd;
    in_we     = we;
    in_wbsel  = wbsel;
    in_alu    = alu;
    in_pc4    = pc4;
    in_funct3 = f3;
  endtask

  // Reference load extraction from the ISA description, using shifts and masks.
  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input int unsigned off,
                                            input logic [31:0] raw);
    int unsigned v;
    case (f3)
      3'b000, 3'b100: begin
        v = (raw >> (8 * off)) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (raw >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = raw;
    endcase
    return v;
  endfunction

  task automatic expectRetire(input string tag, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd);
    logic e_we;
    e_we = we && (wa != 0);
    exp_instret = exp_instret + 1;
    checkOutput({tag, ".we"}, rf_we, e_we);
    checkOutput({tag, ".wa"}, rf_wa, wa);
    checkOutput({tag, ".wd"}, rf_wd, wd);
    checkOutput({tag, ".instret"}, instret, exp_instret);
    last_we = e_we;
    last_wa = wa;
    last_wd = wd;
  endtask

  task automatic doAlu(input string tag, input logic [4:0] rd, input logic we,
                       input logic [1:0] wbsel, input logic [31:0] alu, input logic [31:0] pc4);
    applyStimulus(rd, we, wbsel, alu, pc4, 3'($urandom));
    tick();
    in_valid = 1'b0;
    expectRetire(tag, we, rd, (wbsel == 2'd2) ? pc4 : alu);
  endtask

  // Junk is presented on in_valid while waiting; it must not be accepted.
  task automatic doLoad(input string tag, input logic [4:0] rd, input logic we, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] raw, input int waits);
    applyStimulus(rd, we, WB_MEM, {$urandom} & 32'hFFFF_FFFC | {30'd0, off}, $urandom, f3);
    tick();
    applyStimulus(5'd9, 1'b1, WB_ALU, $urandom, $urandom, 3'd0);
    checkOutput({tag, ".acc_we"}, rf_we, 1'b0);
    for (int i = 0; i < waits; i++) begin
      dmem_rdata = $urandom;
      checkOutput({tag, ".ready"}, in_ready, 1'b0);
      checkOutput({tag, ".busy"}, ld_busy, 1'b1);
      tick();
      checkOutput({tag, ".wait_we"}, rf_we, 1'b0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = raw;
    tick();
    dmem_rvalid = 1'b0;
    in_valid    = 1'b0;
    dmem_rdata  = $urandom;
    expectRetire(tag, we, rd, modelLoad(f3, off, raw));
  endtask

  task automatic checkBypass(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    ra1 = a1;
    ra2 = a2;
    rgf_rd1 = $urandom;
    rgf_rd2 = $urandom;
    #1;
    checkOutput({tag, ".rd1"}, rd1, (last_we && last_wa == a1 && a1 != 0) ? last_wd : rgf_rd1);
    checkOutput({tag, ".rd2"}, rd2, (last_we && last_wa == a2 && a2 != 0) ? last_wd : rgf_rd2);
  endtask

  initial begin
    // Reset, with a stale load response arriving while held.
    dmem_rvalid = 1'b1;
    repeat (2) tick();
    checkOutput("rst.we", rf_we, 1'b0);
    checkOutput("rst.wa", rf_wa, 5'd0);
    checkOutput("rst.wd", rf_wd, 32'd0);
    checkOutput("rst.instret", instret, 64'd0);
    checkOutput("rst.busy", ld_busy, 1'b0);
    checkOutput("rst.ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    checkOutput("stale.we", rf_we, 1'b0);
    checkOutput("stale.instret", instret, 64'd0);

    doAlu("alu", 5'd5, 1'b1, WB_ALU, 32'h1234, 32'h4);
    checkOutput("alu.wd_abs", rf_wd, 32'h0000_1234);
    tick();
    checkOutput("alu.pulse", rf_we, 1'b0);
    doAlu("pc4", 5'd1, 1'b1, WB_PC4, 32'hDEAD, 32'h0000_1008);
    doAlu("sel3", 5'd2, 1'b1, 2'd3, 32'h0BAD_F00D, 32'h1);
    doAlu("rd0", 5'd0, 1'b1, WB_ALU, 32'h5555, 32'h0);
    doAlu("nowe", 5'd3, 1'b0, WB_ALU, 32'h7777, 32'h0);

    doLoad("lb", 5'd4, 1'b1, F3_LB, 2'd3, 32'h80FF_FFFF, 3);
    checkOutput("lb.abs", rf_wd, 32'hFFFF_FF80);
    doLoad("lbu", 5'd4, 1'b1, F3_LBU, 2'd3, 32'h80FF_FFFF, 3);
    checkOutput("lbu.abs", rf_wd, 32'h0000_0080);
    doLoad("lhu", 5'd6, 1'b1, F3_LHU, 2'd2, 32'hBEEF_0000, 1);
    checkOutput("lhu.abs", rf_wd, 32'h0000_BEEF);
    doLoad("lh", 5'd6, 1'b1, F3_LH, 2'd1, 32'h1234_8001, 0);
    checkOutput("lh.abs", rf_wd, 32'hFFFF_8001);
    doLoad("lw", 5'd8, 1'b1, F3_LW, 2'd3, 32'hA5A5_5A5A, 2);
    doLoad("f3odd", 5'd8, 1'b1, 3'b111, 2'd1, 32'h0102_0304, 0);

    // Bypass against a write to x7.
    doAlu("byp", 5'd7, 1'b1, WB_ALU, 32'h0000_CAFE, 32'h0);
    checkBypass("byp.a", 5'd7, 5'd0);
    checkOutput("byp.abs", rd1, 32'h0000_CAFE);
    checkBypass("byp.b", 5'd3, 5'd7);
    tick();
    last_we = 1'b0;
    checkBypass("byp.idle", 5'd7, 5'd7);

    // Reset asserted while a load is outstanding.
    applyStimulus(5'd10, 1'b1, WB_MEM, 32'h0, 32'h0, F3_LW);
    tick();
    in_valid = 1'b0;
    checkOutput("rstld.busy", ld_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstld.ready_async", in_ready, 1'b1);
    checkOutput("rstld.instret_async", instret, 64'd0);
    tick();
    rst_n = 1'b1;
    exp_instret = 0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    tick();
    dmem_rvalid = 1'b0;
    checkOutput("rstld.we", rf_we, 1'b0);
    tick();
    checkOutput("rstld.we2", rf_we, 1'b0);
    checkOutput("rstld.instret", instret, 64'd0);
    checkOutput("rstld.ready", in_ready, 1'b1);

    // Back-to-back: two ALU ops then a load with an immediate response.
    applyStimulus(5'd11, 1'b1, WB_ALU, 32'h11, 32'h0, 3'd0);
    tick();
    expectRetire("b2b.0", 1'b1, 5'd11, 32'h11);
    applyStimulus(5'd12, 1'b1, WB_PC4, 32'h0, 32'h22, 3'd0);
    tick();
    expectRetire("b2b.1", 1'b1, 5'd12, 32'h22);
    applyStimulus(5'd13, 1'b1, WB_MEM, 32'h0, 32'h0, F3_LW);
    tick();
    in_valid = 1'b0;
    checkOutput("b2b.gap", rf_we, 1'b0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h3333_4444;
    tick();
    dmem_rvalid = 1'b0;
    expectRetire("b2b.2", 1'b1, 5'd13, 32'h3333_4444);
    checkOutput("b2b.instret", instret, 64'd3);

    // Random retirements with occasional stale responses in IDLE.
    for (int n = 0; n < 150; n++) begin
      logic [1:0] sel;
      sel = 2'($urandom);
      if (sel == WB_MEM)
        doLoad("rnd.ld", 5'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom,
               int'($urandom_range(0, 3)));
      else
        doAlu("rnd.alu", 5'($urandom), 1'($urandom), sel, $urandom, $urandom);
      checkBypass("rnd.byp", ($urandom_range(0, 1) == 1) ? last_wa : 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = $urandom;
        tick();
        dmem_rvalid = 1'b0;
        last_we = 1'b0;
        checkOutput("rnd.idle_we", rf_we, 1'b0);
        checkOutput("rnd.idle_instret", instret, exp_instret);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv151_wbu.md
Name: rv151_wbu

Overview:
- Writeback unit for the rv151 core; drives the write port of the integer register file (rf_we/rf_wa/rf_wd).
- Accepts one retiring instruction per handshake and selects the result source: ALU, PC+4, or load data.
- For loads, waits for the data-memory response, then extracts, sign- or zero-extends and aligns the data.
- Provides read-port bypass: a value being written this cycle is returned to readers of the same register, covering the register file's synchronous write.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a retiring instruction is presented.
- in_ready  out  1  unit can accept; equals (state==IDLE).
- in_rd  in  5  destination register.
- in_we  in  1  instruction writes rd.
- in_wbsel  in  2  result source: 0=ALU, 1=MEM, 2=PC4; 3 is treated as ALU.
- in_alu  in  32  ALU result; in_alu[1:0] is the load byte offset.
- in_pc4  in  32  PC+4.
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  raw load word.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  32  register-file write data.
- ra1, ra2  in  5  register-file read addresses, looped in from decode.
- rgf_rd1, rgf_rd2  in  32  raw register-file read data.
- rd1, rd2  out  32  bypassed read data.
- ld_busy  out  1  high in WAIT_LD; used by the hazard unit to stall.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rf_we=0; rf_wa=0; rf_wd=0; instret=0; ld_busy=0.
  - Any in-flight load is dropped.
- The state machine has two states, IDLE and WAIT_LD.
- IDLE, in_valid=1, in_wbsel!=MEM (accepted):
  - Next cycle: rf_we = in_we & (in_rd!=0); rf_wa = in_rd; rf_wd = in_alu or in_pc4.
  - Latency is 1 cycle. State stays IDLE.
- IDLE, in_valid=1, in_wbsel==MEM (accepted):
  - Latch rd, we, funct3 and in_alu[1:0]; go to WAIT_LD.
  - rf_we=0 on the next cycle.
- WAIT_LD:
  - in_ready=0 and ld_busy=1.
  - dmem_rvalid is sampled only in this state. The earliest response is the cycle after acceptance; the wait is unbounded.
  - On dmem_rvalid=1: next cycle rf_we = latched_we & (latched_rd!=0), rf_wd = extracted data; state returns to IDLE.
- Load extraction (off = latched in_alu[1:0]):
  - LB/LBU: byte dmem_rdata[8*off+7:8*off], sign-extended for LB, zero-extended for LBU.
  - LH/LHU: half selected by off[1]; off[0] ignored; sign- or zero-extended.
  - LW, and unlisted funct3: full word; off ignored.
- dmem_rvalid in IDLE is ignored, including a stale response arriving after reset.
- rf_we is a one-cycle pulse per retirement; it is never held.
- Writes with rd=0 are suppressed (rf_we=0) but still count as retirements.
- instret increments by 1 in the cycle after each completion: every non-load acceptance, and every load response. It wraps modulo 2^CNT_W.
- Bypass (combinational): rd1 = (rf_we & rf_wa==ra1 & ra1!=0) ? rf_wd : rgf_rd1; rd2 is the same using ra2.
- Reset asserted mid-WAIT_LD: immediate return to IDLE; the load never writes back; instret is cleared.

Decomposition:
- Shared package rv151_pkg holds:
  - WB_ALU/WB_MEM/WB_PC4 encodings;
  - F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU constants;
  - the state enum (IDLE, WAIT_LD).
- One combinational sub-module, rv151_ld_ext (funct3, off, raw -> 32-bit extended data), reused later by the LSU.

Test Plan:
- ALU write: accept in_rd=5, wbsel=ALU, in_alu=0x1234 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x00001234; instret 0->1.
- rd=0 suppression: accept in_rd=0, in_we=1 -> rf_we stays 0; instret still increments.
- Load sign/zero extension: LB off=3, rdata=0x80FFFFFF, rvalid 3 cycles after accept:
  - in_ready=0 and ld_busy=1 for those 3 cycles;
  - then rf_wd=0xFFFFFF80;
  - repeating with LBU gives 0x00000080;
  - LHU off=2, rdata=0xBEEF0000 gives 0x0000BEEF.
- Bypass: rf_we=1, rf_wa=7, rf_wd=0xCAFE, ra1=7, ra2=0, rgf_rd1=0x1 -> rd1=0xCAFE, rd2=rgf_rd2.
- Reset mid-load: accept LW, assert rst_n=0 in WAIT_LD, release, then pulse dmem_rvalid -> rf_we never asserts, instret=0, in_ready=1.
- Back-to-back: ALU on cycles 0 and 1, then LW with immediate rvalid -> rf_we pulses on cycles 1, 2 and 4; instret=3.
